arc4_stream: RTL
================

ARC4_STREAM -- requirements
Module: arc4_stream

Interface
REQ-001 Parameter KEY_BYTES, default 3: key length in bytes, range 1..32; key byte 0 is key[KEY_BYTES*8-1 -: 8].
REQ-002 Parameter DROP_N, default 0: number of initial keystream bytes discarded (RC4-dropN), range 0..1023.
REQ-003 Port clk  input  1: single clock; all state changes on its rising edge.
REQ-004 Port rst  input  1: reset, asynchronous, active-high.
REQ-005 Port en  input  1: start request, accepted only when rdy=1.
REQ-006 Port rdy  output  1: high when idle and able to accept en.
REQ-007 Port key  input  KEY_BYTES*8: cipher key, sampled in the accepting cycle.
REQ-008 Port ct_addr  output  8: ciphertext memory read address.
REQ-009 Port ct_rddata  input  8: ciphertext read data, valid one cycle after ct_addr is presented.
REQ-010 Port pt_addr  output  8: plaintext memory write address.
REQ-011 Port pt_wrdata  output  8: plaintext write data.
REQ-012 Port pt_wren  output  1: plaintext write strobe, one byte per high cycle.
REQ-013 Port err  output  1: sticky; set when en arrives while rdy=0, cleared on the next accepted start.

Function
REQ-014 Message format SHALL be length-prefixed: ct[0] = L (0..255), ct[1..L] = ciphertext; output pt[0] = L, pt[1..L] = plaintext.
REQ-015 Start handshake SHALL be: en=1 with rdy=1 latches key, drops rdy the next cycle and enters INIT; rdy stays 0 until done.
REQ-016 FSM states SHALL be: IDLE, INIT, KSA_RD_I, KSA_RD_J, KSA_SWAP, LEN_RD, LEN_WR, PRGA_RD_I, PRGA_RD_J, PRGA_SWAP, PRGA_RD_K, PRGA_WR, DONE.
REQ-017 INIT SHALL write S[i]=i for i=0..255, one byte per cycle, exactly 256 cycles.
REQ-018 KSA SHALL, for i=0..255, compute j = j + S[i] + key[i mod KEY_BYTES] (mod 256) and swap S[i]/S[j]; i wraps 255->0 only on exit.
REQ-019 LEN_RD/LEN_WR SHALL read ct[0] and write pt[0]=L with a single pt_wren pulse.
REQ-020 PRGA SHALL reset i=j=0, then run DROP_N+L iterations: i=i+1, j=j+S[i], swap, k=S[(S[i]+S[j]) mod 256].
REQ-021 For the first DROP_N iterations, PRGA SHALL discard k with pt_wren=0 and issue no ct reads.
REQ-022 Each kept iteration n (1..L) SHALL write pt[n] = ct[n] XOR k with exactly one pt_wren pulse.
REQ-023 Arithmetic SHALL be 8-bit, wrapping mod 256; the key index counter SHALL wrap at KEY_BYTES, and the drop counter is 10 bits.
REQ-024 A read-after-write hazard where j == i SHALL yield an unchanged S; the swap writes the same value to both locations.
REQ-025 With L=0, the block SHALL write only pt[0]=0, skip PRGA except the drop iterations, and go to DONE.
REQ-026 DONE SHALL last one cycle, then return to IDLE with rdy=1; the next start SHALL re-run INIT.
REQ-027 en while rdy=0 SHALL be ignored (err=1); en held high in DONE SHALL start a new run only from IDLE.
REQ-028 pt_wren SHALL never be high outside LEN_WR and PRGA_WR.

Reset
REQ-029 On rst=1, asynchronously: state=IDLE, rdy=1, pt_wren=0, err=0, ct_addr=0, pt_addr=0, pt_wrdata=0, i=j=0.
REQ-030 Reset mid-run SHALL abort immediately with no further writes; S contents are don't-care after reset.
REQ-031 After rst deasserts, the first rising edge with en=1 SHALL be accepted.

Structure
REQ-032 Package arc4_pkg SHALL hold the FSM state enum, S_SIZE=256, and the drop-counter width constant.
REQ-033 One sub-module s_mem SHALL be used: a 256x8 single-port synchronous RAM with 1-cycle read latency, registered inside arc4_stream's hierarchy.
REQ-034 KEY_BYTES and DROP_N SHALL be checked at elaboration; out-of-range values are a fatal error.

Verification
REQ-035 KEY_BYTES=3, key=24'h4B6579, ct = 09,BB,F3,16,E8,D9,40,AF,0A,D3 -> pt = 09,"Plaintext" (50 6C 61 69 6E 74 65 78 74), rdy returns to 1.
REQ-036 KEY_BYTES=4, key=32'h57696B69, ct = 05,10,21,BF,04,20 -> pt = 05,"pedia" (70 65 64 69 61).
REQ-037 L=0 with any key -> exactly one pt_wren pulse, pt[0]=00, then rdy=1.
REQ-038 DROP_N=1 with the REQ-035 key and ct[1..] = plaintext XOR keystream bytes 2..10 -> pt recovers "Plaintext"; the write count equals L+1.
REQ-039 rst pulsed during PRGA after 3 pt writes -> pt_wren=0 within the reset cycle, rdy=1; a rerun of REQ-035 passes.
REQ-040 en pulsed during KSA -> err=1 and the run is unaffected; the next accepted en clears err.

Source files
------------

// File: rtl/arc4_pkg.sv
// Shared types and constants for the ARC4 stream decryptor.
package arc4_pkg;

  localparam int S_SIZE = 256;
  localparam int DROP_W = 10;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    INIT      = 4'd1,
    KSA_RD_I  = 4'd2,
    KSA_RD_J  = 4'd3,
    KSA_SWAP  = 4'd4,
    LEN_RD    = 4'd5,
    LEN_WR    = 4'd6,
    PRGA_RD_I = 4'd7,
    PRGA_RD_J = 4'd8,
    PRGA_SWAP = 4'd9,
    PRGA_RD_K = 4'd10,
    PRGA_WR   = 4'd11,
    DONE      = 4'd12
  } state_e;

  function automatic logic [7:0] add8(input logic [7:0] a, input logic [7:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/arc4_stream_if.sv
// Start handshake, ciphertext read port and plaintext write port of arc4_stream.
interface arc4_stream_if #(parameter int KEY_BYTES = 3);

  logic                   en;
  logic                   rdy;
  logic [KEY_BYTES*8-1:0] key;
  logic [7:0]             ct_addr;
  logic [7:0]             ct_rddata;
  logic [7:0]             pt_addr;
  logic [7:0]             pt_wrdata;
  logic                   pt_wren;
  logic                   err;

  modport master (
    output en, key, ct_rddata,
    input  rdy, ct_addr, pt_addr, pt_wrdata, pt_wren, err
  );

  modport slave (
    input  en, key, ct_rddata,
    output rdy, ct_addr, pt_addr, pt_wrdata, pt_wren, err
  );

endinterface

// File: rtl/s_mem.sv
// 256x8 single-port synchronous RAM holding the RC4 permutation; 1-cycle read latency.
module s_mem
  import arc4_pkg::*;
(
  input  logic       clk,
  input  logic       we_i,
  input  logic [7:0] addr_i,
  input  logic [7:0] wdata_i,
  output logic [7:0] rdata_o
);

  logic [7:0] mem_q [S_SIZE];
  logic [7:0] rdata_q;

  // write port plus registered read of the same address
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/arc4_stream.sv
// RC4(-dropN) decryptor of a length-prefixed message: KSA, optional drop, then PRGA XOR.
module arc4_stream
  import arc4_pkg::*;
#(
  parameter int KEY_BYTES = 3,
  parameter int DROP_N    = 0
) (
  input logic          clk,
  input logic          rst,
  arc4_stream_if.slave bus
);

  localparam int KW = KEY_BYTES * 8;

  if (KEY_BYTES < 1 || KEY_BYTES > 32) begin : g_bad_key_bytes
    $fatal(1, "arc4_stream: KEY_BYTES must be in 1..32");
  end
  if (DROP_N < 0 || DROP_N > 1023) begin : g_bad_drop_n
    $fatal(1, "arc4_stream: DROP_N must be in 0..1023");
  end

  state_e            state_q;
  logic              ph_q;
  logic [7:0]        i_q, j_q, si_q, sj_q, len_q;
  logic [DROP_W-1:0] drop_q;
  logic [KW-1:0]     key_q, key_rot;
  logic              rdy_q, err_q, pt_wren_q;
  logic [7:0]        ct_addr_q, pt_addr_q, pt_wrdata_q;

  logic       s_we;
  logic [7:0] s_addr, s_wdata, s_rdata, ksa_j, prga_j;

  // Key byte i mod KEY_BYTES always sits in the top byte; rotate once per KSA step.
  assign key_rot = (key_q << 8) | (key_q >> (KW - 8));
  assign ksa_j   = add8(add8(j_q, s_rdata), key_q[KW-1 -: 8]);
  assign prga_j  = add8(j_q, s_rdata);

  s_mem u_s_mem (
    .clk     (clk),
    .we_i    (s_we),
    .addr_i  (s_addr),
    .wdata_i (s_wdata),
    .rdata_o (s_rdata)
  );

  // permutation RAM address/write control for the current state
  always_comb begin
    s_we    = 1'b0;
    s_addr  = 8'd0;
    s_wdata = 8'd0;
    case (state_q)
      INIT: begin
        s_we    = 1'b1;
        s_addr  = i_q;
        s_wdata = i_q;
      end
      KSA_RD_I:  s_addr = i_q;
      KSA_RD_J:  s_addr = ksa_j;
      PRGA_RD_I: s_addr = add8(i_q, 8'd1);
      PRGA_RD_J: s_addr = prga_j;
      KSA_SWAP, PRGA_SWAP: begin
        // S[j] first, then S[i] from the captured S[j]: j == i leaves S unchanged
        s_we    = 1'b1;
        s_addr  = ph_q ? i_q : j_q;
        s_wdata = ph_q ? sj_q : si_q;
      end
      PRGA_RD_K: s_addr = add8(si_q, sj_q);
      default: begin
        s_we = 1'b0;
      end
    endcase
  end

  // control FSM with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ph_q        <= 1'b0;
      i_q         <= 8'd0;
      j_q         <= 8'd0;
      si_q        <= 8'd0;
      sj_q        <= 8'd0;
      len_q       <= 8'd0;
      drop_q      <= '0;
      key_q       <= '0;
      rdy_q       <= 1'b1;
      err_q       <= 1'b0;
      pt_wren_q   <= 1'b0;
      ct_addr_q   <= 8'd0;
      pt_addr_q   <= 8'd0;
      pt_wrdata_q <= 8'd0;
    end else begin
      pt_wren_q <= 1'b0;
      if (state_q != IDLE && bus.en) begin
        err_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (bus.en) begin
            key_q     <= bus.key;
            rdy_q     <= 1'b0;
            err_q     <= 1'b0;
            i_q       <= 8'd0;
            j_q       <= 8'd0;
            ph_q      <= 1'b0;
            ct_addr_q <= 8'd0;
            state_q   <= INIT;
          end
        end
        INIT: begin
          i_q <= add8(i_q, 8'd1);
          if (i_q == 8'd255) begin
            state_q <= KSA_RD_I;
          end
        end
        KSA_RD_I: state_q <= KSA_RD_J;
        KSA_RD_J: begin
          si_q    <= s_rdata;
          j_q     <= ksa_j;
          state_q <= KSA_SWAP;
        end
        KSA_SWAP: begin
          if (!ph_q) begin
            sj_q <= s_rdata;
            ph_q <= 1'b1;
          end else begin
            ph_q    <= 1'b0;
            i_q     <= add8(i_q, 8'd1);
            key_q   <= key_rot;
            state_q <= (i_q == 8'd255) ? LEN_RD : KSA_RD_I;
          end
        end
        LEN_RD: begin
          // ct_addr has been 0 since the start, so ct[0] is already on ct_rddata
          len_q       <= bus.ct_rddata;
          pt_addr_q   <= 8'd0;
          pt_wrdata_q <= bus.ct_rddata;
          pt_wren_q   <= 1'b1;
          state_q     <= LEN_WR;
        end
        LEN_WR: begin
          i_q     <= 8'd0;
          j_q     <= 8'd0;
          drop_q  <= DROP_W'(DROP_N);
          state_q <= (DROP_N == 0 && len_q == 8'd0) ? DONE : PRGA_RD_I;
        end
        PRGA_RD_I: begin
          i_q     <= add8(i_q, 8'd1);
          state_q <= PRGA_RD_J;
        end
        PRGA_RD_J: begin
          si_q    <= s_rdata;
          j_q     <= prga_j;
          state_q <= PRGA_SWAP;
        end
        PRGA_SWAP: begin
          if (!ph_q) begin
            sj_q <= s_rdata;
            ph_q <= 1'b1;
          end else begin
            ph_q <= 1'b0;
            if (drop_q == '0) begin
              ct_addr_q <= add8(ct_addr_q, 8'd1);
            end
            state_q <= PRGA_RD_K;
          end
        end
        PRGA_RD_K: begin
          if (!ph_q) begin
            ph_q <= 1'b1;
          end else begin
            ph_q <= 1'b0;
            if (drop_q == '0) begin
              pt_wren_q   <= 1'b1;
              pt_addr_q   <= ct_addr_q;
              pt_wrdata_q <= bus.ct_rddata ^ s_rdata;
            end
            state_q <= PRGA_WR;
          end
        end
        PRGA_WR: begin
          if (drop_q != '0) begin
            drop_q  <= drop_q - DROP_W'(1);
            state_q <= (drop_q == DROP_W'(1) && len_q == 8'd0) ? DONE : PRGA_RD_I;
          end else begin
            state_q <= (ct_addr_q == len_q) ? DONE : PRGA_RD_I;
          end
        end
        DONE: begin
          rdy_q   <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          rdy_q   <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.rdy       = rdy_q;
  assign bus.err       = err_q;
  assign bus.ct_addr   = ct_addr_q;
  assign bus.pt_addr   = pt_addr_q;
  assign bus.pt_wrdata = pt_wrdata_q;
  assign bus.pt_wren   = pt_wren_q;

endmodule
